mmu_tlb: RTL and testbench
==========================

# mmu_tlb

Parametrised MIPS32 joint TLB with N-channel registered address translation. Replaces the fixed kseg0/kseg1 direct-map translator between the pipeline address stages and the I/D caches. Adds mapped kuseg/kseg2/kseg3 translation, CP0 TLBWI/TLBWR/TLBP/TLBR support, a Random counter, and per-channel exception and uncached flags. Lookups have a fixed 1-cycle latency.

## Interface
Parameters:
- TLBNUM, 16: number of entries; power of two, 4..64. IW = log2(TLBNUM).
- NCH, 4: lookup channels (inst, inst2, data, data2).
- MON_UC, 1: when 1, 0x8010_0000–0x803F_FFFF is forced uncached on channels flagged in DCH_MASK.
- DCH_MASK, 4'b1100: bit c set means channel c is a data channel (MON_UC and dirty check apply).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  NCH  per-channel lookup request
- req_vaddr  in  32*NCH  virtual address; channel c at [32c+31:32c]
- req_store  in  NCH  access is a store (dirty check)
- cur_asid  in  8  EntryHi.ASID for lookups and probe
- rsp_valid  out  NCH  response valid, 1 cycle after req_valid
- rsp_paddr  out  32*NCH  physical address
- rsp_uncached  out  NCH  access bypasses cache
- rsp_refill  out  NCH  mapped address, no matching entry
- rsp_invalid  out  NCH  matching entry, selected V=0
- rsp_modified  out  NCH  store to a page with D=0
- we  in  1  write strobe
- we_random  in  1  with we: 1 = TLBWR (index = random), 0 = TLBWI (index = w_index)
- w_index  in  IW  TLBWI / TLBR index
- w_entry  in  78  {VPN2[18:0], ASID[7:0], G, PFN0[19:0], C0[2:0], D0, V0, PFN1[19:0], C1[2:0], D1, V1}
- wired  in  IW  CP0 Wired
- wired_we  in  1  Wired was written
- random  out  IW  CP0 Random
- probe_req  in  1  TLBP
- probe_vpn2  in  19  EntryHi.VPN2 for probe
- probe_valid  out  1  probe result valid
- probe_miss  out  1  Index.P
- probe_index  out  IW  matching index, 0 on miss
- rd_req  in  1  TLBR
- rd_valid  out  1  read result valid
- rd_entry  out  78  entry at w_index

## Operation
- Segments by vaddr[31:29]:
  - 100 (kseg0): unmapped, paddr = {3'b0, va[28:0]}, cached, unless MON_UC applies.
  - 101 (kseg1): unmapped, same paddr, uncached.
  - All others are mapped.
- Mapped match: entry matches when VPN2 == va[31:13] and (G or ASID == cur_asid). va[12] selects the odd page (PFN1/C1/D1/V1), else the even page.
  - paddr = {PFN[19:0], va[11:0]}.
  - uncached when C == 3'd2.
- Multiple matching entries (software error): the lowest index wins. No shutdown.
- Fault priority: refill, then invalid, then modified. Only one flag is set. When a flag is set, paddr is 0.
- MON_UC check on data channels: va[31]=1 and va[30:22]=0 and va[21:20]≠0.
- TLBWI writes w_entry to w_index. TLBWR writes it to the current random value.
- TLBP compares VPN2 and ASID/G against all entries; the result uses the lowest matching index.
- TLBR returns the full entry at w_index.
- Random:
  - Decrements by 1 every cycle.
  - When random ≤ wired, the next value is TLBNUM-1.
  - wired_we loads TLBNUM-1.
  - If wired ≥ TLBNUM-1, random holds TLBNUM-1.

## Timing
- Lookup, probe and read inputs are sampled at edge N. Results are registered and valid during cycle N+1 only. No backpressure; every channel is independent.
- Array write takes effect at the edge where we=1. A lookup, probe or read sampled at that same edge sees the old contents. A request one cycle later sees the new entry.
- TLBWR uses the random value present during the we cycle. Random still decrements at that edge.
- Reset (async assert) values:
  - All entries zero, so V0=V1=0 and G=0.
  - random = TLBNUM-1.
  - All rsp_*, probe_*, rd_* outputs are 0.
- Reset asserted mid-request drops the pending response. No rsp_valid appears after reset release until a new request.
- rsp_* other than rsp_valid are don't-care when rsp_valid=0. They must nonetheless be driven, not X.

## Test plan
- Reset, then lookup va 0x9FC0_0000 ch0 and 0xBFAF_0000 ch2 → next cycle paddr 0x1FC0_0000 cached; 0x1FAF_0000 uncached; no faults.
- MON_UC=1: ch2 va 0x8010_0004 → paddr 0x0010_0004 uncached. Same va on ch0 → cached.
- TLBWI idx 3, VPN2=0x00002, ASID=5, PFN0=0x12345 V0=1 D0=0 C0=3, PFN1=0x54321 V1=0. Then with cur_asid=5:
  - load va 0x0000_4ABC → paddr 0x1234_5ABC.
  - store same va → rsp_modified.
  - va 0x0000_5000 → rsp_invalid.
  - cur_asid=6 → rsp_refill.
- TLBP VPN2=0x00002 ASID 5 → probe_miss=0, probe_index=3. TLBP VPN2=0x7FFFF → probe_miss=1, index 0. TLBR idx 3 → rd_entry equals written value.
- wired=4 with wired_we → random=15, then counts 14…4, then wraps to 15. TLBWR when random=9 writes entry 9, confirmed by TLBR.
- Write idx 3 and look up its va in the same cycle → refill (old contents). The next-cycle lookup hits.

Source files
------------

// File: rtl/mmu_tlb_if.sv
// Lookup channel bundle between the pipeline address stages and the joint TLB.
// The pipeline side drives requests; the TLB side returns registered translations.
interface mmu_tlb_if #(
   parameter int unsigned NCH = 4
);
   logic [NCH-1:0]      req_valid;
   logic [32*NCH-1:0]   req_vaddr;
   logic [NCH-1:0]      req_store;
   logic [7:0]          cur_asid;
   logic [NCH-1:0]      rsp_valid;
   logic [32*NCH-1:0]   rsp_paddr;
   logic [NCH-1:0]      rsp_uncached;
   logic [NCH-1:0]      rsp_refill;
   logic [NCH-1:0]      rsp_invalid;
   logic [NCH-1:0]      rsp_modified;

   modport master (
      output req_valid, req_vaddr, req_store, cur_asid,
      input  rsp_valid, rsp_paddr, rsp_uncached, rsp_refill, rsp_invalid, rsp_modified
   );

   modport slave (
      input  req_valid, req_vaddr, req_store, cur_asid,
      output rsp_valid, rsp_paddr, rsp_uncached, rsp_refill, rsp_invalid, rsp_modified
   );
endinterface

// File: rtl/mmu_tlb.sv
// MIPS32 joint TLB: N independent registered lookup channels plus CP0 TLBWI/TLBWR/TLBP/TLBR
// and the Random counter. Every result is valid exactly one cycle after its request.
module mmu_tlb #(
   parameter int unsigned      TLBNUM   = 16,
   parameter int unsigned      NCH      = 4,
   parameter bit               MON_UC   = 1'b1,
   parameter logic [NCH-1:0]   DCH_MASK = 4'b1100,
   localparam int unsigned     IW       = $clog2(TLBNUM)
) (
   input  logic             clk,
   input  logic             resetn,
   mmu_tlb_if.slave         lk,
   input  logic             we,
   input  logic             we_random,
   input  logic [IW-1:0]    w_index,
   input  logic [77:0]      w_entry,
   input  logic [IW-1:0]    wired,
   input  logic             wired_we,
   output logic [IW-1:0]    random,
   input  logic             probe_req,
   input  logic [18:0]      probe_vpn2,
   output logic             probe_valid,
   output logic             probe_miss,
   output logic [IW-1:0]    probe_index,
   input  logic             rd_req,
   output logic             rd_valid,
   output logic [77:0]      rd_entry
);

   localparam logic [IW-1:0] RMAX = IW'(TLBNUM - 1);

   typedef struct packed {
      logic [31:0] paddr;
      logic        unc;
      logic        refill;
      logic        invalid;
      logic        modified;
   } xlate_t;

   // Entry layout: {VPN2[77:59], ASID[58:51], G[50], even page [49:25], odd page [24:0]}
   logic [77:0] entry_q [TLBNUM];
   logic [77:0] entry_d [TLBNUM];

   logic [IW-1:0]     random_q, random_d;
   logic [NCH-1:0]    rsp_valid_q, rsp_valid_d;
   logic [32*NCH-1:0] rsp_paddr_q, rsp_paddr_d;
   logic [NCH-1:0]    rsp_unc_q, rsp_unc_d;
   logic [NCH-1:0]    rsp_refill_q, rsp_refill_d;
   logic [NCH-1:0]    rsp_invalid_q, rsp_invalid_d;
   logic [NCH-1:0]    rsp_mod_q, rsp_mod_d;
   logic              probe_valid_q, probe_valid_d;
   logic              probe_miss_q, probe_miss_d;
   logic [IW-1:0]     probe_index_q, probe_index_d;
   logic              rd_valid_q, rd_valid_d;
   logic [77:0]       rd_entry_q, rd_entry_d;
   logic [IW:0]       probe_hit;

   // Returns {found, index}; scanning downward leaves the lowest matching index.
   function automatic logic [IW:0] find(input logic [18:0] vpn2, input logic [7:0] asid);
      logic [IW:0] r;
      r = '0;
      for (int i = int'(TLBNUM) - 1; i >= 0; i--) begin
         if (entry_q[i][77:59] == vpn2 && (entry_q[i][50] || entry_q[i][58:51] == asid)) begin
            r = {1'b1, IW'(i)};
         end
      end
      return r;
   endfunction

   function automatic xlate_t xlate(input logic [31:0] va, input logic [7:0] asid,
                                    input logic is_data, input logic store);
      xlate_t      r;
      logic [IW:0] f;
      logic [77:0] e;
      logic [19:0] pfn;
      logic [2:0]  cc;
      logic        d;
      logic        v;
      r = '0;
      if (va[31:30] == 2'b10) begin
         r.paddr = {3'b000, va[28:0]};
         // kseg1 always uncached; monitor window in kseg0 only for data channels
         r.unc   = va[29] | (MON_UC && is_data && va[30:22] == 9'd0 && va[21:20] != 2'd0);
      end else begin
         f = find(va[31:13], asid);
         e = entry_q[f[IW-1:0]];
         if (va[12]) {pfn, cc, d, v} = e[24:0];
         else        {pfn, cc, d, v} = e[49:25];
         if (!f[IW])                        r.refill   = 1'b1;
         else if (!v)                       r.invalid  = 1'b1;
         else if (is_data && store && !d)   r.modified = 1'b1;
         else begin
            r.paddr = {pfn, va[11:0]};
            r.unc   = (cc == 3'd2);
         end
      end
      return r;
   endfunction

   always_comb begin
      for (int i = 0; i < int'(TLBNUM); i++) entry_d[i] = entry_q[i];
      if (we) entry_d[we_random ? random_q : w_index] = w_entry;
   end

   always_comb begin
      if (wired_we || wired >= RMAX || random_q <= wired) random_d = RMAX;
      else                                                 random_d = random_q - 1'b1;
   end

   always_comb begin
      xlate_t x;
      rsp_valid_d   = lk.req_valid;
      rsp_paddr_d   = '0;
      rsp_unc_d     = '0;
      rsp_refill_d  = '0;
      rsp_invalid_d = '0;
      rsp_mod_d     = '0;
      for (int c = 0; c < int'(NCH); c++) begin
         x = xlate(lk.req_vaddr[32*c +: 32], lk.cur_asid, DCH_MASK[c], lk.req_store[c]);
         if (lk.req_valid[c]) begin
            rsp_paddr_d[32*c +: 32] = x.paddr;
            rsp_unc_d[c]            = x.unc;
            rsp_refill_d[c]         = x.refill;
            rsp_invalid_d[c]        = x.invalid;
            rsp_mod_d[c]            = x.modified;
         end
      end
   end

   always_comb begin
      probe_hit     = find(probe_vpn2, lk.cur_asid);
      probe_valid_d = probe_req;
      probe_miss_d  = probe_req & ~probe_hit[IW];
      probe_index_d = (probe_req && probe_hit[IW]) ? probe_hit[IW-1:0] : '0;
      rd_valid_d    = rd_req;
      rd_entry_d    = rd_req ? entry_q[w_index] : '0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < int'(TLBNUM); i++) entry_q[i] <= '0;
         random_q      <= RMAX;
         rsp_valid_q   <= '0;
         rsp_paddr_q   <= '0;
         rsp_unc_q     <= '0;
         rsp_refill_q  <= '0;
         rsp_invalid_q <= '0;
         rsp_mod_q     <= '0;
         probe_valid_q <= 1'b0;
         probe_miss_q  <= 1'b0;
         probe_index_q <= '0;
         rd_valid_q    <= 1'b0;
         rd_entry_q    <= '0;
      end else begin
         for (int i = 0; i < int'(TLBNUM); i++) entry_q[i] <= entry_d[i];
         random_q      <= random_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_paddr_q   <= rsp_paddr_d;
         rsp_unc_q     <= rsp_unc_d;
         rsp_refill_q  <= rsp_refill_d;
         rsp_invalid_q <= rsp_invalid_d;
         rsp_mod_q     <= rsp_mod_d;
         probe_valid_q <= probe_valid_d;
         probe_miss_q  <= probe_miss_d;
         probe_index_q <= probe_index_d;
         rd_valid_q    <= rd_valid_d;
         rd_entry_q    <= rd_entry_d;
      end
   end

   assign lk.rsp_valid    = rsp_valid_q;
   assign lk.rsp_paddr    = rsp_paddr_q;
   assign lk.rsp_uncached = rsp_unc_q;
   assign lk.rsp_refill   = rsp_refill_q;
   assign lk.rsp_invalid  = rsp_invalid_q;
   assign lk.rsp_modified = rsp_mod_q;
   assign random          = random_q;
   assign probe_valid     = probe_valid_q;
   assign probe_miss      = probe_miss_q;
   assign probe_index     = probe_index_q;
   assign rd_valid        = rd_valid_q;
   assign rd_entry        = rd_entry_q;

endmodule

// File: tb/tb_mmu_tlb.sv
// Directed bench for mmu_tlb: unmapped segments, mapped translation and faults, CP0 ops,
// Random counter, write/lookup ordering and asynchronous reset.
module tb_mmu_tlb;
   logic        clk;
   logic        resetn;
   logic        we;
   logic        we_random;
   logic [3:0]  w_index;
   logic [77:0] w_entry;
   logic [3:0]  wired;
   logic        wired_we;
   logic [3:0]  random;
   logic        probe_req;
   logic [18:0] probe_vpn2;
   logic        probe_valid;
   logic        probe_miss;
   logic [3:0]  probe_index;
   logic        rd_req;
   logic        rd_valid;
   logic [77:0] rd_entry;

   int total = 0;
   int bad   = 0;

   mmu_tlb_if #(.NCH(4)) lk ();

   mmu_tlb dut (
      .clk         (clk),
      .resetn      (resetn),
      .lk          (lk),
      .we          (we),
      .we_random   (we_random),
      .w_index     (w_index),
      .w_entry     (w_entry),
      .wired       (wired),
      .wired_we    (wired_we),
      .random      (random),
      .probe_req   (probe_req),
      .probe_vpn2  (probe_vpn2),
      .probe_valid (probe_valid),
      .probe_miss  (probe_miss),
      .probe_index (probe_index),
      .rd_req      (rd_req),
      .rd_valid    (rd_valid),
      .rd_entry    (rd_entry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [77:0] obs, input logic [77:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [77:0] mk(input logic [18:0] vpn2, input logic [7:0] asid,
                                      input logic g, input logic [19:0] pfn0,
                                      input logic [2:0] c0, input logic d0, input logic v0,
                                      input logic [19:0] pfn1, input logic [2:0] c1,
                                      input logic d1, input logic v1);
      return {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1};
   endfunction

   function automatic logic [31:0] pa(input int c);
      return lk.rsp_paddr[32*c +: 32];
   endfunction

   task automatic req(input int c, input logic [31:0] va, input logic st);
      lk.req_valid[c]         = 1'b1;
      lk.req_vaddr[32*c +: 32] = va;
      lk.req_store[c]         = st;
   endtask

   task automatic clr();
      lk.req_valid = '0;
      lk.req_store = '0;
      lk.req_vaddr = '0;
   endtask

   logic [77:0] e1, e2, e3, e4;

   initial begin
      e1 = mk(19'h00002, 8'd5, 1'b0, 20'h12345, 3'd3, 1'b0, 1'b1, 20'h54321, 3'd0, 1'b0, 1'b0);
      e2 = mk(19'h00010, 8'd7, 1'b1, 20'hABCDE, 3'd2, 1'b1, 1'b1, 20'h11111, 3'd3, 1'b1, 1'b1);
      e3 = mk(19'h00100, 8'd5, 1'b0, 20'h00777, 3'd3, 1'b1, 1'b1, 20'h00000, 3'd0, 1'b0, 1'b0);
      e4 = mk(19'h00100, 8'd5, 1'b0, 20'h00888, 3'd3, 1'b1, 1'b1, 20'h00000, 3'd0, 1'b0, 1'b0);
      resetn = 1'b0; we = 1'b0; we_random = 1'b0; w_index = '0; w_entry = '0;
      wired = '0; wired_we = 1'b0; probe_req = 1'b0; probe_vpn2 = '0; rd_req = 1'b0;
      lk.cur_asid = 8'd0;
      clr();
      tick();
      tick();
      chk("rst_rsp_valid", 78'(lk.rsp_valid), 78'(4'b0000));
      chk("rst_random", 78'(random), 78'(4'd15));
      chk("rst_probe", 78'({probe_valid, probe_miss, probe_index}), 78'(0));
      chk("rst_rd", 78'({rd_valid, rd_entry}), 78'(0));
      resetn = 1'b1;
      tick();

      // unmapped kseg0/kseg1
      req(0, 32'h9FC0_0000, 1'b0);
      req(2, 32'hBFAF_0000, 1'b0);
      tick();
      clr();
      chk("seg_valid", 78'(lk.rsp_valid), 78'(4'b0101));
      chk("kseg0_pa", 78'(pa(0)), 78'(32'h1FC0_0000));
      chk("kseg1_pa", 78'(pa(2)), 78'(32'h1FAF_0000));
      chk("seg_unc", 78'({lk.rsp_uncached[2], lk.rsp_uncached[0]}), 78'(2'b10));
      chk("seg_faults", 78'({lk.rsp_refill[2], lk.rsp_refill[0], lk.rsp_invalid[2],
                             lk.rsp_invalid[0], lk.rsp_modified[2], lk.rsp_modified[0]}), 78'(0));
      tick();
      chk("valid_one_cycle", 78'(lk.rsp_valid), 78'(0));

      // monitor uncached window only on data channels
      req(0, 32'h8010_0004, 1'b0);
      req(2, 32'h8010_0004, 1'b0);
      tick();
      clr();
      chk("monuc_pa_ch2", 78'(pa(2)), 78'(32'h0010_0004));
      chk("monuc_pa_ch0", 78'(pa(0)), 78'(32'h0010_0004));
      chk("monuc_unc", 78'({lk.rsp_uncached[2], lk.rsp_uncached[0]}), 78'(2'b10));

      // TLBWI index 3
      we = 1'b1; w_index = 4'd3; w_entry = e1;
      tick();
      we = 1'b0;
      lk.cur_asid = 8'd5;
      req(2, 32'h0000_4ABC, 1'b0);
      tick();
      clr();
      chk("map_load_pa", 78'(pa(2)), 78'(32'h1234_5ABC));
      chk("map_load_flags", 78'({lk.rsp_uncached[2], lk.rsp_refill[2], lk.rsp_invalid[2],
                                 lk.rsp_modified[2]}), 78'(0));
      req(2, 32'h0000_4ABC, 1'b1);
      req(0, 32'h0000_4ABC, 1'b1);
      tick();
      clr();
      chk("store_mod_d", 78'({lk.rsp_refill[2], lk.rsp_invalid[2], lk.rsp_modified[2], pa(2)}),
          78'({3'b001, 32'h0}));
      chk("store_inst_ch", 78'({lk.rsp_modified[0], pa(0)}), 78'({1'b0, 32'h1234_5ABC}));
      req(2, 32'h0000_5000, 1'b0);
      tick();
      clr();
      chk("odd_invalid", 78'({lk.rsp_refill[2], lk.rsp_invalid[2], lk.rsp_modified[2], pa(2)}),
          78'({3'b010, 32'h0}));
      lk.cur_asid = 8'd6;
      req(1, 32'h0000_4ABC, 1'b0);
      tick();
      clr();
      chk("asid_refill", 78'({lk.rsp_refill[1], lk.rsp_invalid[1], lk.rsp_modified[1], pa(1)}),
          78'({3'b100, 32'h0}));
      lk.cur_asid = 8'd5;
      req(3, 32'hC000_0000, 1'b0);
      tick();
      clr();
      chk("kseg2_refill", 78'(lk.rsp_refill[3]), 78'(1'b1));

      // TLBP / TLBR
      probe_req = 1'b1; probe_vpn2 = 19'h00002;
      tick();
      probe_vpn2 = 19'h7FFFF;
      chk("probe_hit", 78'({probe_valid, probe_miss, probe_index}), 78'({2'b10, 4'd3}));
      tick();
      probe_req = 1'b0;
      chk("probe_miss", 78'({probe_valid, probe_miss, probe_index}), 78'({2'b11, 4'd0}));
      rd_req = 1'b1; w_index = 4'd3;
      tick();
      rd_req = 1'b0;
      chk("tlbr_idx3", 78'({rd_valid, rd_entry[76:0]}), 78'({1'b1, e1[76:0]}));
      chk("tlbr_idx3_msb", 78'(rd_entry[77]), 78'(e1[77]));
      tick();
      chk("probe_rd_drop", 78'({probe_valid, rd_valid}), 78'(0));

      // Random counter with wired=4
      wired = 4'd4; wired_we = 1'b1;
      tick();
      wired_we = 1'b0;
      chk("rand_load", 78'(random), 78'(4'd15));
      for (int k = 14; k >= 4; k--) begin
         tick();
         chk("rand_count", 78'(random), 78'(k));
      end
      tick();
      chk("rand_wrap", 78'(random), 78'(4'd15));
      for (int k = 0; k < 6; k++) tick();
      chk("rand_at9", 78'(random), 78'(4'd9));
      we = 1'b1; we_random = 1'b1; w_index = 4'd0; w_entry = e2;
      tick();
      we = 1'b0; we_random = 1'b0;
      chk("rand_after_wr", 78'(random), 78'(4'd8));
      rd_req = 1'b1; w_index = 4'd9;
      tick();
      chk("tlbwr_idx9", 78'(rd_entry), e2);
      w_index = 4'd0;
      tick();
      rd_req = 1'b0;
      chk("tlbwr_idx0_untouched", 78'(rd_entry), 78'(0));

      // global entry with different ASID, C=2 uncached, store with D=1
      req(3, 32'h0002_0123, 1'b1);
      tick();
      clr();
      chk("global_hit", 78'({lk.rsp_uncached[3], lk.rsp_refill[3], lk.rsp_invalid[3],
                             lk.rsp_modified[3], pa(3)}), 78'({4'b1000, 32'hABCD_E123}));

      // write and lookup in the same cycle sees old contents
      we = 1'b1; w_index = 4'd3; w_entry = e3;
      req(2, 32'h0020_0010, 1'b0);
      tick();
      we = 1'b0;
      chk("same_cycle_refill", 78'({lk.rsp_refill[2], pa(2)}), 78'({1'b1, 32'h0}));
      tick();
      clr();
      chk("next_cycle_hit", 78'({lk.rsp_refill[2], pa(2)}), 78'({1'b0, 32'h0077_7010}));

      // duplicate match: lowest index wins
      we = 1'b1; w_index = 4'd5; w_entry = e4;
      tick();
      we = 1'b0;
      req(0, 32'h0020_0010, 1'b0);
      probe_req = 1'b1; probe_vpn2 = 19'h00100;
      tick();
      clr();
      probe_req = 1'b0;
      chk("dup_lookup", 78'(pa(0)), 78'(32'h0077_7010));
      chk("dup_probe", 78'({probe_miss, probe_index}), 78'({1'b0, 4'd3}));

      // async reset drops pending response and clears array
      req(1, 32'h8000_0000, 1'b0);
      tick();
      clr();
      chk("pre_rst_valid", 78'(lk.rsp_valid), 78'(4'b0010));
      resetn = 1'b0;
      #1;
      chk("async_rst_valid", 78'(lk.rsp_valid), 78'(0));
      chk("async_rst_random", 78'(random), 78'(4'd15));
      #2;
      resetn = 1'b1;
      tick();
      chk("post_rst_valid", 78'(lk.rsp_valid), 78'(0));
      lk.cur_asid = 8'd5;
      req(2, 32'h0020_0010, 1'b0);
      tick();
      clr();
      chk("post_rst_refill", 78'(lk.rsp_refill[2]), 78'(1'b1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
